lock_chamber_controller: RTL and testbench
==========================================

Name: lock_chamber_controller

Overview:
- Parametrised next-generation controller for the two-gate lock/interlock chamber.
- Adds timed gate motion, timed fill and drain with a level counter, abort handling, denial reporting and a configurable chamber depth.
- Sits between the board switches/keys and the status LEDs/HEX drivers.
- Enforces the interlock at all times:
  - never both gates open or moving;
  - never filling or draining with a gate off closed.

Parameters:
- MAX_LEVEL, 4: full-chamber level count; must be >= 1.
- LEVEL_W, 3: Level width; must satisfy 2^LEVEL_W > MAX_LEVEL.
- FILL_STEP, 3: cycles per level increment while filling; must be >= 1.
- DRAIN_STEP, 2: cycles per level decrement while draining; must be >= 1.
- GATE_CYCLES, 2: cycles a gate spends opening or closing; must be >= 1.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- OuterReq  in  1  switch, level-sensitive; 1 = request outer (low-side) gate open.
- InnerReq  in  1  switch, level-sensitive; 1 = request inner (high-side) gate open.
- FillKey  in  1  active-low pushbutton; a press starts a fill.
- DrainKey  in  1  active-low pushbutton; a press starts a drain.
- OuterOpen  out  1  outer gate fully open.
- InnerOpen  out  1  inner gate fully open.
- OuterMoving  out  1  outer gate opening or closing.
- InnerMoving  out  1  inner gate opening or closing.
- Filling  out  1  chamber filling.
- Draining  out  1  chamber draining.
- Level  out  LEVEL_W  current chamber level, 0..MAX_LEVEL.
- Full  out  1  Level == MAX_LEVEL.
- Empty  out  1  Level == 0.
- Denied  out  1  a gate request is present but illegal.
- State  out  4  FSM state code, for debug/HEX display.

Behaviour:
- Reset (Reset=0, asynchronous, may occur mid-operation):
  - State=IDLE, Level=0, all step/gate counters 0.
  - Both synchronisers and key-history flops reset to idle values: switches 0, keys 1.
  - All outputs 0 except Empty=1.
  - Chamber is defined drained on reset, regardless of prior Level.
- Input conditioning:
  - All four inputs pass through 2-flop synchronisers.
  - Key press = synced key 1 in the previous cycle and 0 now; one event per press, holding the key does not repeat.
  - Input change sampled at edge k is acted on at edge k+2.
  - All outputs are registered or decoded from registered state.
- State codes: IDLE=0, FILL=1, DRAIN=2, OUT_OPENING=3, OUT_OPEN=4, OUT_CLOSING=5, IN_OPENING=6, IN_OPEN=7, IN_CLOSING=8.
- IDLE, priority order:
  - OuterReq && Level==0 -> OUT_OPENING.
  - InnerReq && Level==MAX_LEVEL -> IN_OPENING.
  - Fill press alone && !Full -> FILL.
  - Drain press alone && !Empty -> DRAIN.
  - Fill and drain pressed in the same cycle: both ignored.
  - Presses in any state other than IDLE/FILL/DRAIN: discarded, not queued.
- Denied:
  - Asserted in IDLE when OuterReq && Level!=0, or InnerReq && Level!=MAX_LEVEL, and no gate transition is taken this cycle.
  - 0 in every other state.
- FILL:
  - Step counter counts FILL_STEP cycles; at terminal count Level+1 and counter clears.
  - When Level becomes MAX_LEVEL -> IDLE on the same edge.
  - Drain press -> IDLE, Level held, counter cleared.
  - Fill press ignored.
- DRAIN: symmetric to FILL with DRAIN_STEP, decrementing toward 0; fill press aborts.
- OUT_OPENING:
  - Holds GATE_CYCLES cycles, then -> OUT_OPEN.
  - Completes even if OuterReq drops.
- OUT_OPEN: OuterReq==0 -> OUT_CLOSING.
- OUT_CLOSING:
  - Holds GATE_CYCLES cycles, then -> IDLE.
  - A reasserted request takes effect only from IDLE.
- Inner gate: identical through the IN_* states.
- Output decode:
  - OuterOpen = (State==OUT_OPEN).
  - OuterMoving = OUT_OPENING or OUT_CLOSING.
  - Filling = FILL; Draining = DRAIN.
  - Inner outputs decoded likewise.
- Level never wraps; saturates at 0 and MAX_LEVEL by construction.

Test Plan (defaults: MAX_LEVEL=4, FILL_STEP=3, DRAIN_STEP=2, GATE_CYCLES=2):
1. Reset low 3 cycles, then high, no inputs -> all outputs 0, Empty=1, Level=0, State=0.
2. Outer gate cycle:
   - OuterReq=1 sampled at edge k -> OuterMoving=1 after edges k+2..k+3, OuterOpen=1 after edge k+4.
   - FillKey pressed while open -> Level stays 0.
   - OuterReq=0 -> 2 cycles OuterMoving, then IDLE.
3. Full fill: FillKey pressed once -> Filling=1; Level steps 1,2,3,4 at 3-cycle intervals; at Level=4 Filling=0 and Full=1 on the same edge.
4. Illegal gate and abort:
   - Fill, then DrainKey press at Level=2 -> IDLE, Level=2.
   - InnerReq=1 -> Denied=1, InnerMoving=0.
   - OuterReq=1 -> Denied=1.
5. Simultaneous requests at Level=4:
   - OuterReq=InnerReq=1 -> inner gate opens, OuterOpen never 1.
   - While inner open, DrainKey press ignored.
6. Reset mid-operation: Reset asserted mid-cycle during FILL at Level=3 -> Level=0, Filling=0, Empty=1 immediately, before the next edge.

Source files
------------

// File: rtl/lock_chamber_controller.sv
`default_nettype none
// ============================================================================
//  Module   : lock_chamber_controller
//  Purpose  : Two-gate lock chamber controller with timed gate motion, timed
//             fill/drain driving a level counter, abort handling and denial
//             reporting. The interlock is structural: only one activity state
//             (fill, drain or one gate's motion/open) can be held at a time,
//             and gates leave IDLE only at Level 0 (outer) or full (inner).
//  Revision : 1.0  initial release
// ============================================================================
module lock_chamber_controller #(
  parameter int MAX_LEVEL   = 4,
  parameter int LEVEL_W     = 3,
  parameter int FILL_STEP   = 3,
  parameter int DRAIN_STEP  = 2,
  parameter int GATE_CYCLES = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               outer_req_i,
  input  logic               inner_req_i,
  input  logic               fill_key_ni,
  input  logic               drain_key_ni,
  output logic               outer_open_o,
  output logic               inner_open_o,
  output logic               outer_moving_o,
  output logic               inner_moving_o,
  output logic               filling_o,
  output logic               draining_o,
  output logic [LEVEL_W-1:0] level_o,
  output logic               full_o,
  output logic               empty_o,
  output logic               denied_o,
  output logic [3:0]         state_o
);

  localparam int STEP_MAX = (FILL_STEP > DRAIN_STEP) ? FILL_STEP : DRAIN_STEP;
  localparam int STEP_W   = (STEP_MAX > 1) ? $clog2(STEP_MAX) : 1;
  localparam int GATE_W   = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

  localparam logic [LEVEL_W-1:0] MAX_LVL    = LEVEL_W'(MAX_LEVEL);
  localparam logic [STEP_W-1:0]  FILL_LAST  = STEP_W'(FILL_STEP - 1);
  localparam logic [STEP_W-1:0]  DRAIN_LAST = STEP_W'(DRAIN_STEP - 1);
  localparam logic [GATE_W-1:0]  GATE_LAST  = GATE_W'(GATE_CYCLES - 1);

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_FILL        = 4'd1,
    ST_DRAIN       = 4'd2,
    ST_OUT_OPENING = 4'd3,
    ST_OUT_OPEN    = 4'd4,
    ST_OUT_CLOSING = 4'd5,
    ST_IN_OPENING  = 4'd6,
    ST_IN_OPEN     = 4'd7,
    ST_IN_CLOSING  = 4'd8
  } state_e;

  state_e               state_q, state_d;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic [STEP_W-1:0]    step_q,  step_d;
  logic [GATE_W-1:0]    gate_q,  gate_d;

  logic outer_s1_q, outer_s2_q, inner_s1_q, inner_s2_q;
  logic fill_s1_q,  fill_s2_q,  fill_prev_q;
  logic drain_s1_q, drain_s2_q, drain_prev_q;

  logic w_fill_press, w_drain_press, w_full, w_empty, w_denied;

  // Input synchronisers and key history; keys idle high, switches idle low
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outer_s1_q   <= 1'b0;
      outer_s2_q   <= 1'b0;
      inner_s1_q   <= 1'b0;
      inner_s2_q   <= 1'b0;
      fill_s1_q    <= 1'b1;
      fill_s2_q    <= 1'b1;
      fill_prev_q  <= 1'b1;
      drain_s1_q   <= 1'b1;
      drain_s2_q   <= 1'b1;
      drain_prev_q <= 1'b1;
    end else begin
      outer_s1_q   <= outer_req_i;
      outer_s2_q   <= outer_s1_q;
      inner_s1_q   <= inner_req_i;
      inner_s2_q   <= inner_s1_q;
      fill_s1_q    <= fill_key_ni;
      fill_s2_q    <= fill_s1_q;
      fill_prev_q  <= fill_s2_q;
      drain_s1_q   <= drain_key_ni;
      drain_s2_q   <= drain_s1_q;
      drain_prev_q <= drain_s2_q;
    end
  end

  // A press is the falling edge of the synchronised key, one event per press
  assign w_fill_press  = fill_prev_q  & ~fill_s2_q;
  assign w_drain_press = drain_prev_q & ~drain_s2_q;
  assign w_full        = (level_q == MAX_LVL);
  assign w_empty       = (level_q == '0);

  // State, level and counter registers; reset defines the chamber drained
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      level_q <= '0;
      step_q  <= '0;
      gate_q  <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      step_q  <= step_d;
      gate_q  <= gate_d;
    end
  end

  // Next-state logic; fill/drain only start from IDLE with both gates closed
  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    step_d   = step_q;
    gate_d   = gate_q;
    w_denied = 1'b0;
    case (state_q)
      ST_IDLE: begin
        step_d = '0;
        gate_d = '0;
        if (outer_s2_q && w_empty) begin
          state_d = ST_OUT_OPENING;
        end else if (inner_s2_q && w_full) begin
          state_d = ST_IN_OPENING;
        end else begin
          w_denied = (outer_s2_q && !w_empty) || (inner_s2_q && !w_full);
          if (w_fill_press && !w_drain_press && !w_full) begin
            state_d = ST_FILL;
          end else if (w_drain_press && !w_fill_press && !w_empty) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_FILL: begin
        if (w_drain_press) begin
          state_d = ST_IDLE;
          step_d  = '0;
        end else if (step_q == FILL_LAST) begin
          step_d  = '0;
          level_d = level_q + LEVEL_W'(1);
          if (level_d == MAX_LVL) state_d = ST_IDLE;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      ST_DRAIN: begin
        if (w_fill_press) begin
          state_d = ST_IDLE;
          step_d  = '0;
        end else if (step_q == DRAIN_LAST) begin
          step_d  = '0;
          level_d = level_q - LEVEL_W'(1);
          if (level_d == '0) state_d = ST_IDLE;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      ST_OUT_OPENING, ST_OUT_CLOSING, ST_IN_OPENING, ST_IN_CLOSING: begin
        if (gate_q == GATE_LAST) begin
          gate_d = '0;
          case (state_q)
            ST_OUT_OPENING: state_d = ST_OUT_OPEN;
            ST_IN_OPENING:  state_d = ST_IN_OPEN;
            default:        state_d = ST_IDLE;
          endcase
        end else begin
          gate_d = gate_q + GATE_W'(1);
        end
      end
      ST_OUT_OPEN: begin
        gate_d = '0;
        if (!outer_s2_q) state_d = ST_OUT_CLOSING;
      end
      ST_IN_OPEN: begin
        gate_d = '0;
        if (!inner_s2_q) state_d = ST_IN_CLOSING;
      end
      default: begin
        state_d = ST_IDLE;
        step_d  = '0;
        gate_d  = '0;
      end
    endcase
  end

  // Output decode from registered state
  assign outer_open_o   = (state_q == ST_OUT_OPEN);
  assign inner_open_o   = (state_q == ST_IN_OPEN);
  assign outer_moving_o = (state_q == ST_OUT_OPENING) || (state_q == ST_OUT_CLOSING);
  assign inner_moving_o = (state_q == ST_IN_OPENING)  || (state_q == ST_IN_CLOSING);
  assign filling_o      = (state_q == ST_FILL);
  assign draining_o     = (state_q == ST_DRAIN);
  assign level_o        = level_q;
  assign full_o         = w_full;
  assign empty_o        = w_empty;
  assign denied_o       = w_denied;
  assign state_o        = state_q;

endmodule
`default_nettype wire

// File: tb/tb_lock_chamber_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lock_chamber_controller
//  Purpose  : Directed bench for lock_chamber_controller with default params.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lock_chamber_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       outer_req, inner_req, fill_key, drain_key;
  logic       outer_open, inner_open, outer_moving, inner_moving;
  logic       filling, draining, full, empty, denied;
  logic [2:0] level;
  logic [3:0] state;

  int vectors = 0;
  int miscompares = 0;

  lock_chamber_controller dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .outer_req_i    (outer_req),
    .inner_req_i    (inner_req),
    .fill_key_ni    (fill_key),
    .drain_key_ni   (drain_key),
    .outer_open_o   (outer_open),
    .inner_open_o   (inner_open),
    .outer_moving_o (outer_moving),
    .inner_moving_o (inner_moving),
    .filling_o      (filling),
    .draining_o     (draining),
    .level_o        (level),
    .full_o         (full),
    .empty_o        (empty),
    .denied_o       (denied),
    .state_o        (state)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse a key low for two cycles; returns just after the edge that acts on it
  task automatic press_fill();
    fill_key = 1'b0; tick(2); fill_key = 1'b1; tick();
  endtask

  task automatic press_drain();
    drain_key = 1'b0; tick(2); drain_key = 1'b1; tick();
  endtask

  initial begin
    rst_n = 1'b0; outer_req = 1'b0; inner_req = 1'b0;
    fill_key = 1'b1; drain_key = 1'b1;

    // 1. reset
    tick(3);
    rst_n = 1'b1;
    tick(3);
    chk("rst_state", state, 0);
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_flags", {outer_open, inner_open, outer_moving, inner_moving, filling, draining, denied}, 0);

    // 2. outer gate cycle
    outer_req = 1'b1;
    tick(2);
    chk("out_wait_k1", state, 0);
    tick();
    chk("out_opening_k2", outer_moving, 1);
    chk("out_opening_st", state, 3);
    tick();
    chk("out_opening_k3", outer_moving, 1);
    tick();
    chk("out_open_k4", outer_open, 1);
    chk("out_open_mov", outer_moving, 0);
    fill_key = 1'b0; tick(3); fill_key = 1'b1; tick(4);
    chk("open_fill_lvl", level, 0);
    chk("open_fill_st", state, 4);
    outer_req = 1'b0;
    tick(2);
    chk("out_still_open", state, 4);
    tick();
    chk("out_closing1", state, 5);
    chk("out_closing1_mv", outer_moving, 1);
    tick();
    chk("out_closing2", state, 5);
    tick();
    chk("out_closed", state, 0);
    chk("out_closed_mv", outer_moving, 0);

    // 3. full fill
    press_fill();
    chk("fill_start", filling, 1);
    chk("fill_lvl0", level, 0);
    tick(2);
    chk("fill_e2", level, 0);
    tick();
    chk("fill_e3", level, 1);
    tick(3);
    chk("fill_e6", level, 2);
    tick(3);
    chk("fill_e9", level, 3);
    tick(2);
    chk("fill_e11_lvl", level, 3);
    chk("fill_e11_fl", filling, 1);
    tick();
    chk("fill_e12_lvl", level, 4);
    chk("fill_e12_fl", filling, 0);
    chk("fill_e12_full", full, 1);
    chk("fill_e12_st", state, 0);
    chk("fill_e12_empty", empty, 0);

    // 4. abort at level 2, then denied requests
    rst_n = 1'b0; tick(3); rst_n = 1'b1; tick(2);
    chk("rst2_level", level, 0);
    press_fill();
    tick(4);
    chk("ab_e4", level, 1);
    drain_key = 1'b0;
    tick(2);
    chk("ab_e6_lvl", level, 2);
    chk("ab_e6_fl", filling, 1);
    drain_key = 1'b1;
    tick();
    chk("ab_idle", state, 0);
    chk("ab_lvl", level, 2);
    tick(6);
    chk("ab_held", level, 2);
    inner_req = 1'b1;
    tick(3);
    chk("inner_denied", denied, 1);
    chk("inner_nomove", inner_moving, 0);
    chk("inner_den_st", state, 0);
    inner_req = 1'b0;
    tick(3);
    chk("inner_undenied", denied, 0);
    outer_req = 1'b1;
    tick(3);
    chk("outer_denied", denied, 1);
    chk("outer_nomove", outer_moving, 0);
    outer_req = 1'b0;
    tick(3);
    chk("outer_undenied", denied, 0);

    // 5. both requests at full level
    press_fill();
    tick(6);
    chk("refill_full", full, 1);
    chk("refill_idle", state, 0);
    outer_req = 1'b1; inner_req = 1'b1;
    tick(3);
    chk("both_in_opening", state, 6);
    chk("both_in_mv", inner_moving, 1);
    chk("both_no_deny", denied, 0);
    tick(2);
    chk("both_in_open", inner_open, 1);
    chk("both_out_closed", {outer_open, outer_moving}, 0);
    press_drain();
    tick(3);
    chk("open_drain_st", state, 7);
    chk("open_drain_lvl", level, 4);
    chk("open_drain_out", outer_open, 0);
    outer_req = 1'b0; inner_req = 1'b0;
    tick(3);
    chk("in_closing", state, 8);
    tick(2);
    chk("in_closed", state, 0);
    tick(3);
    chk("no_queued_drain", state, 0);
    chk("no_queued_lvl", level, 4);

    // drain with fill-press abort at level 2
    press_drain();
    chk("drain_start", draining, 1);
    tick(2);
    chk("drain_d2", level, 3);
    fill_key = 1'b0;
    tick(2);
    chk("drain_d4", level, 2);
    chk("drain_d4_dr", draining, 1);
    fill_key = 1'b1;
    tick();
    chk("drain_abort_st", state, 0);
    chk("drain_abort_lvl", level, 2);

    // 6. asynchronous reset mid-fill at level 3
    press_fill();
    tick(3);
    chk("pre_rst_lvl", level, 3);
    tick();
    #3 rst_n = 1'b0;
    #1;
    chk("async_lvl", level, 0);
    chk("async_fill", filling, 0);
    chk("async_empty", empty, 1);
    chk("async_state", state, 0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk("post_rst_st", state, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
